// File: rtl/axusb_pkg.sv
// Shared key codes, controller states and field helpers
// for the time-set controller.
package axusb_pkg;

  localparam int HW = 5;
  localparam int MW = 6;

  localparam logic [4:0] KEY_NULL   = 5'd0;
  localparam logic [4:0] KEY_D0     = 5'd1;
  localparam logic [4:0] KEY_D9     = 5'd10;
  localparam logic [4:0] KEY_SET    = 5'd13;
  localparam logic [4:0] KEY_CANCEL = 5'd14;
  localparam logic [4:0] KEY_NEXT   = 5'd15;

  typedef enum logic [2:0] {
    RUN,
    EDIT_H,
    EDIT_M,
    EDIT_S,
    COMMIT
  } ts_state_t;

  function automatic logic [3:0] tens_of(
    input logic [5:0] v
  );
    tens_of = 4'd0;
    for (int i = 1; i <= 5; i++)
      if (v >= 6'(10 * i)) tens_of = 4'(i);
  endfunction

  function automatic logic is_edit(
    input ts_state_t s
  );
    return s inside {EDIT_H, EDIT_M, EDIT_S};
  endfunction

  function automatic ts_state_t next_field(
    input ts_state_t s
  );
    case (s)
      EDIT_H:  return EDIT_M;
      EDIT_M:  return EDIT_S;
      default: return EDIT_H;
    endcase
  endfunction

endpackage

// File: rtl/blink_timer.sv
// Free-running blink divider; phase toggles every DIV
// cycles and restarts from phase 0 on clear.
module blink_timer
  import axusb_pkg::*;
#(
  parameter int DIV = 16_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic phase_o
);

  localparam int W = $clog2(DIV + 1);

  logic [W-1:0] cnt_q;
  logic         phase_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else if (clr_i) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else if (cnt_q == W'(DIV - 1)) begin
      cnt_q   <= '0;
      phase_q <= ~phase_q;
    end else begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign phase_o = phase_q;

endmodule

// File: rtl/time_set_ctrl.sv
// Keypad time-set controller: gates the seconds chain,
// edits a shadow copy of the time and commits it with one load.
module time_set_ctrl
  import axusb_pkg::*;
#(
  parameter int BLINK_DIV    = 16_000_000,
  parameter int IDLE_TIMEOUT = 320_000_000
) (
  input  logic          mclk,
  input  logic          rst,
  input  logic [4:0]    key_code,
  input  logic [HW-1:0] cur_hour,
  input  logic [MW-1:0] cur_min,
  input  logic [MW-1:0] cur_sec,
  output logic          run_en,
  output logic          load,
  output logic [HW-1:0] ld_hour,
  output logic [MW-1:0] ld_min,
  output logic [MW-1:0] ld_sec,
  output logic [HW-1:0] disp_hour,
  output logic [MW-1:0] disp_min,
  output logic [MW-1:0] disp_sec,
  output logic [5:0]    blink_mask,
  output logic          editing
);

  localparam int TW = $clog2(IDLE_TIMEOUT + 1);

  ts_state_t     state_q, state_d;
  logic [4:0]    key_q;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          idx_q, idx_d;
  logic [HW-1:0] sh_hour_q;
  logic [MW-1:0] sh_min_q, sh_sec_q;
  logic          run_en_q, load_q, editing_q;
  logic [HW-1:0] ld_hour_q;
  logic [MW-1:0] ld_min_q, ld_sec_q;

  logic       press, is_dig, expire;
  logic       wr_en, blink_clr, phase;
  logic [3:0] dig, tens;
  logic [5:0] fval, ones, tval, wr_val;
  logic [5:0] sel;

  always_comb begin
    press  = (key_code != KEY_NULL) && (key_q == KEY_NULL);
    is_dig = (key_code >= KEY_D0) && (key_code <= KEY_D9);
    dig    = 4'(key_code - KEY_D0);
    case (state_q)
      EDIT_M:  fval = sh_min_q;
      EDIT_S:  fval = sh_sec_q;
      default: fval = {1'b0, sh_hour_q};
    endcase
    tens = tens_of(fval);
    ones = fval - 6'(tens) * 6'd10;
    // Hour tens that would overflow 23 drops the old ones digit
    tval = 6'(dig) * 6'd10 + ones;
    if (state_q == EDIT_H && tval > 6'd23)
      tval = 6'(dig) * 6'd10;
    expire  = tmo_q == TW'(IDLE_TIMEOUT - 1);
    state_d = state_q;
    idx_d   = idx_q;
    wr_en   = 1'b0;
    wr_val  = tval;
    unique case (state_q)
      RUN: begin
        if (press && key_code == KEY_SET) begin
          state_d = EDIT_H;
          idx_d   = 1'b0;
        end
      end
      EDIT_H, EDIT_M, EDIT_S: begin
        if (press) begin
          unique case (1'b1)
            is_dig && !idx_q: begin
              if (dig <= (state_q == EDIT_H ? 4'd2 : 4'd5)) begin
                wr_en = 1'b1;
                idx_d = 1'b1;
              end
            end
            is_dig && idx_q: begin
              if (!(state_q == EDIT_H && tens == 4'd2
                    && dig > 4'd3)) begin
                wr_en   = 1'b1;
                wr_val  = 6'(tens) * 6'd10 + 6'(dig);
                idx_d   = 1'b0;
                state_d = next_field(state_q);
              end
            end
            key_code == KEY_NEXT: begin
              idx_d   = 1'b0;
              state_d = next_field(state_q);
            end
            key_code == KEY_SET:    state_d = COMMIT;
            key_code == KEY_CANCEL: state_d = RUN;
            default: ;
          endcase
        end else if (expire) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
    blink_clr = is_edit(state_d) && (state_d != state_q);
    tmo_d = (press || !is_edit(state_q)) ? '0 : tmo_q + TW'(1);
  end

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      state_q   <= RUN;
      key_q     <= KEY_NULL;
      tmo_q     <= '0;
      idx_q     <= 1'b0;
      sh_hour_q <= '0;
      sh_min_q  <= '0;
      sh_sec_q  <= '0;
      run_en_q  <= 1'b1;
      load_q    <= 1'b0;
      editing_q <= 1'b0;
      ld_hour_q <= '0;
      ld_min_q  <= '0;
      ld_sec_q  <= '0;
    end else begin
      state_q   <= state_d;
      key_q     <= key_code;
      tmo_q     <= tmo_d;
      idx_q     <= idx_d;
      run_en_q  <= state_d == RUN;
      editing_q <= state_d != RUN;
      load_q    <= state_d == COMMIT;
      if (state_d == COMMIT) begin
        ld_hour_q <= sh_hour_q;
        ld_min_q  <= sh_min_q;
        ld_sec_q  <= sh_sec_q;
      end
      if (state_q == RUN && state_d == EDIT_H) begin
        sh_hour_q <= cur_hour;
        sh_min_q  <= cur_min;
        sh_sec_q  <= cur_sec;
      end else if (wr_en) begin
        case (state_q)
          EDIT_H:  sh_hour_q <= wr_val[HW-1:0];
          EDIT_M:  sh_min_q  <= wr_val;
          default: sh_sec_q  <= wr_val;
        endcase
      end
    end
  end

  blink_timer #(
    .DIV (BLINK_DIV)
  ) u_blink (
    .clk_i   (mclk),
    .rst_i   (rst),
    .clr_i   (blink_clr),
    .phase_o (phase)
  );

  always_comb begin
    case (state_q)
      EDIT_H:  sel = 6'b110000;
      EDIT_M:  sel = 6'b001100;
      EDIT_S:  sel = 6'b000011;
      default: sel = 6'b000000;
    endcase
    blink_mask = phase ? sel : 6'b0;
  end

  assign disp_hour = (state_q == RUN) ? cur_hour : sh_hour_q;
  assign disp_min  = (state_q == RUN) ? cur_min  : sh_min_q;
  assign disp_sec  = (state_q == RUN) ? cur_sec  : sh_sec_q;
  assign run_en    = run_en_q;
  assign load      = load_q;
  assign editing   = editing_q;
  assign ld_hour   = ld_hour_q;
  assign ld_min    = ld_min_q;
  assign ld_sec    = ld_sec_q;

endmodule
